// File: rtl/snn_two_layer_lif_param.sv
// Two-layer leaky integrate-and-fire spiking network with per-synapse delays,
// saturating membranes, refractory periods, saturating layer-2 spike counters
// and a registered debug membrane readout.
module snn_two_layer_lif_param #(
  parameter int M1 = 24,
  parameter int N1 = 8,
  parameter int N2 = 2,
  parameter int WB = 2,
  parameter int MB = 6,
  parameter int DW = 3,
  parameter int RB = 2,
  parameter int CW = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [M1-1:0]              input_spikes,
  input  logic [N1*M1*WB-1:0]        weights1,
  input  logic [N2*N1*WB-1:0]        weights2,
  input  logic [MB-1:0]              threshold1,
  input  logic [MB-1:0]              threshold2,
  input  logic [MB-1:0]              decay1,
  input  logic [MB-1:0]              decay2,
  input  logic [RB-1:0]              refractory1,
  input  logic [RB-1:0]              refractory2,
  input  logic [N1*M1*DW-1:0]        delay_values1,
  input  logic [N1*M1-1:0]           delays1,
  input  logic [N2*N1*DW-1:0]        delay_values2,
  input  logic [N2*N1-1:0]           delays2,
  input  logic                       count_clear,
  input  logic [$clog2(N1+N2)-1:0]   dbg_sel,
  output logic [MB-1:0]              dbg_membrane,
  output logic [N1-1:0]              output_spikes_l1,
  output logic [N2-1:0]              output_spikes,
  output logic [N2*CW-1:0]           spike_count
);

  localparam int DEPTH = (1 << DW) - 1;
  localparam int AW    = MB + WB + $clog2(M1) + 2;
  localparam int SW    = $clog2(N1 + N2);

  // hist bit k holds the spike seen k+1 enabled steps ago; tap 0 is the live input
  logic [DEPTH-1:0] hist1_r [M1];
  logic [DEPTH-1:0] hist2_r [N1];
  logic [MB-1:0]    mem1_r  [N1];
  logic [MB-1:0]    mem2_r  [N2];
  logic [RB-1:0]    refr1_r [N1];
  logic [RB-1:0]    refr2_r [N2];
  logic [N1-1:0]    spk1_r;
  logic [N2-1:0]    spk2_r;
  logic [CW-1:0]    cnt_r   [N2];
  logic [MB-1:0]    dbg_r;

  logic [AW-1:0]    acc1_s;
  logic [AW-1:0]    acc2_s;
  logic [MB-1:0]    clamp1_s [N1];
  logic [MB-1:0]    clamp2_s [N2];
  logic [N1-1:0]    fire1_s;
  logic [N2-1:0]    fire2_s;
  logic [MB-1:0]    dbg_s;

  function automatic logic [AW-1:0] sext_w(input logic [WB-1:0] w);
    return {{(AW-WB){w[WB-1]}}, w};
  endfunction

  // Clamp a two's-complement accumulator into the unsigned membrane range
  function automatic logic [MB-1:0] clamp_mb(input logic [AW-1:0] a);
    logic [MB-1:0] r;
    if (a[AW-1]) begin
      r = {MB{1'b0}};
    end else if (a[AW-2:MB] != {(AW-1-MB){1'b0}}) begin
      r = {MB{1'b1}};
    end else begin
      r = a[MB-1:0];
    end
    return r;
  endfunction

  function automatic logic tap_sel(input logic now, input logic [DEPTH-1:0] hist,
                                   input logic en, input logic [DW-1:0] dv);
    logic r;
    if (!en || dv == {DW{1'b0}}) begin
      r = now;
    end else begin
      r = hist[dv - DW'(1)];
    end
    return r;
  endfunction

  // Layer-1 delayed synaptic sum, leak, clamp and fire decision
  always_comb begin
    acc1_s  = {AW{1'b0}};
    fire1_s = {N1{1'b0}};
    for (int n = 0; n < N1; n++) begin
      acc1_s = {{(AW-MB){1'b0}}, mem1_r[n]} - {{(AW-MB){1'b0}}, decay1};
      for (int i = 0; i < M1; i++) begin
        if (tap_sel(input_spikes[i], hist1_r[i], delays1[n*M1+i],
                    delay_values1[(n*M1+i)*DW +: DW])) begin
          acc1_s = acc1_s + sext_w(weights1[(n*M1+i)*WB +: WB]);
        end else begin
          acc1_s = acc1_s;
        end
      end
      clamp1_s[n] = clamp_mb(acc1_s);
      fire1_s[n]  = (refr1_r[n] == {RB{1'b0}}) && (clamp1_s[n] >= threshold1);
    end
  end

  // Layer-2 delayed synaptic sum over registered layer-1 spikes
  always_comb begin
    acc2_s  = {AW{1'b0}};
    fire2_s = {N2{1'b0}};
    for (int n = 0; n < N2; n++) begin
      acc2_s = {{(AW-MB){1'b0}}, mem2_r[n]} - {{(AW-MB){1'b0}}, decay2};
      for (int i = 0; i < N1; i++) begin
        if (tap_sel(spk1_r[i], hist2_r[i], delays2[n*N1+i],
                    delay_values2[(n*N1+i)*DW +: DW])) begin
          acc2_s = acc2_s + sext_w(weights2[(n*N1+i)*WB +: WB]);
        end else begin
          acc2_s = acc2_s;
        end
      end
      clamp2_s[n] = clamp_mb(acc2_s);
      fire2_s[n]  = (refr2_r[n] == {RB{1'b0}}) && (clamp2_s[n] >= threshold2);
    end
  end

  // Layer-1 neuron state and input delay lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spk1_r <= {N1{1'b0}};
      for (int n = 0; n < N1; n++) begin
        mem1_r[n]  <= {MB{1'b0}};
        refr1_r[n] <= {RB{1'b0}};
      end
      for (int i = 0; i < M1; i++) hist1_r[i] <= {DEPTH{1'b0}};
    end else if (enable) begin
      for (int n = 0; n < N1; n++) begin
        if (refr1_r[n] != {RB{1'b0}}) begin
          refr1_r[n] <= refr1_r[n] - RB'(1);
          mem1_r[n]  <= {MB{1'b0}};
          spk1_r[n]  <= 1'b0;
        end else if (fire1_s[n]) begin
          refr1_r[n] <= refractory1;
          mem1_r[n]  <= {MB{1'b0}};
          spk1_r[n]  <= 1'b1;
        end else begin
          mem1_r[n]  <= clamp1_s[n];
          spk1_r[n]  <= 1'b0;
        end
      end
      for (int i = 0; i < M1; i++) hist1_r[i] <= {hist1_r[i][DEPTH-2:0], input_spikes[i]};
    end
  end

  // Layer-2 neuron state and delay lines fed by registered layer-1 spikes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spk2_r <= {N2{1'b0}};
      for (int n = 0; n < N2; n++) begin
        mem2_r[n]  <= {MB{1'b0}};
        refr2_r[n] <= {RB{1'b0}};
      end
      for (int i = 0; i < N1; i++) hist2_r[i] <= {DEPTH{1'b0}};
    end else if (enable) begin
      for (int n = 0; n < N2; n++) begin
        if (refr2_r[n] != {RB{1'b0}}) begin
          refr2_r[n] <= refr2_r[n] - RB'(1);
          mem2_r[n]  <= {MB{1'b0}};
          spk2_r[n]  <= 1'b0;
        end else if (fire2_s[n]) begin
          refr2_r[n] <= refractory2;
          mem2_r[n]  <= {MB{1'b0}};
          spk2_r[n]  <= 1'b1;
        end else begin
          mem2_r[n]  <= clamp2_s[n];
          spk2_r[n]  <= 1'b0;
        end
      end
      for (int i = 0; i < N1; i++) hist2_r[i] <= {hist2_r[i][DEPTH-2:0], spk1_r[i]};
    end
  end

  // Saturating layer-2 spike counters; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N2; n++) cnt_r[n] <= {CW{1'b0}};
    end else if (count_clear) begin
      for (int n = 0; n < N2; n++) cnt_r[n] <= {CW{1'b0}};
    end else if (enable) begin
      for (int n = 0; n < N2; n++) begin
        if (fire2_s[n] && cnt_r[n] != {CW{1'b1}}) begin
          cnt_r[n] <= cnt_r[n] + CW'(1);
        end
      end
    end
  end

  // Debug membrane mux; layer-1 neurons first, out-of-range index reads 0
  always_comb begin
    dbg_s = {MB{1'b0}};
    for (int n = 0; n < N1; n++) begin
      if (dbg_sel == SW'(n)) dbg_s = mem1_r[n];
      else dbg_s = dbg_s;
    end
    for (int n = 0; n < N2; n++) begin
      if (dbg_sel == SW'(N1 + n)) dbg_s = mem2_r[n];
      else dbg_s = dbg_s;
    end
  end

  // Debug readout register, sampled every clock regardless of enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dbg_r <= {MB{1'b0}};
    else       dbg_r <= dbg_s;
  end

  // Pack per-neuron counters onto the flat count bus
  always_comb begin
    spike_count = {(N2*CW){1'b0}};
    for (int n = 0; n < N2; n++) spike_count[n*CW +: CW] = cnt_r[n];
  end

  assign dbg_membrane     = dbg_r;
  assign output_spikes_l1 = spk1_r;
  assign output_spikes    = spk2_r;

endmodule

// File: tb/tb_snn_two_layer_lif_param.sv
// Scoreboard bench for snn_two_layer_lif_param: a step-level reference model
// pushes expected outputs; a separate monitor pops and compares them.
module tb_snn_two_layer_lif_param;
  localparam int M1 = 24, N1 = 8, N2 = 2, WB = 2, MB = 6, DW = 3, RB = 2, CW = 8;
  localparam int SW = 4;
  localparam int MMAX = (1 << MB) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, enable, count_clear;
  logic [M1-1:0] input_spikes;
  logic [N1*M1*WB-1:0] weights1;
  logic [N2*N1*WB-1:0] weights2;
  logic [MB-1:0] threshold1, threshold2, decay1, decay2;
  logic [RB-1:0] refractory1, refractory2;
  logic [N1*M1*DW-1:0] delay_values1;
  logic [N1*M1-1:0] delays1;
  logic [N2*N1*DW-1:0] delay_values2;
  logic [N2*N1-1:0] delays2;
  logic [SW-1:0] dbg_sel;
  logic [MB-1:0] dbg_membrane;
  logic [N1-1:0] output_spikes_l1;
  logic [N2-1:0] output_spikes;
  logic [N2*CW-1:0] spike_count;

  always #5 clk = ~clk;

  snn_two_layer_lif_param dut (
    .clk(clk), .reset(reset), .enable(enable), .input_spikes(input_spikes),
    .weights1(weights1), .weights2(weights2),
    .threshold1(threshold1), .threshold2(threshold2),
    .decay1(decay1), .decay2(decay2),
    .refractory1(refractory1), .refractory2(refractory2),
    .delay_values1(delay_values1), .delays1(delays1),
    .delay_values2(delay_values2), .delays2(delays2),
    .count_clear(count_clear), .dbg_sel(dbg_sel), .dbg_membrane(dbg_membrane),
    .output_spikes_l1(output_spikes_l1), .output_spikes(output_spikes),
    .spike_count(spike_count)
  );

  typedef struct packed {
    logic [N1-1:0]    l1;
    logic [N2-1:0]    l2;
    logic [N2*CW-1:0] cnt;
    logic [MB-1:0]    dbg;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  event mon_ev;

  // Reference model state: membranes, refractory counts, spike histories per step
  int m1[N1], r1[N1], m2[N2], r2[N2], cnt[N2];
  bit [N1-1:0] l1;
  bit [N2-1:0] l2;
  bit [M1-1:0] in_hist[4096];
  bit [N1-1:0] l1_hist[4096];
  int s;

  function automatic int clampv(int a);
    return (a < 0) ? 0 : ((a > MMAX) ? MMAX : a);
  endfunction

  function automatic int wval(logic [WB-1:0] w);
    logic signed [WB-1:0] sw;
    sw = w;
    return int'(sw);
  endfunction

  task automatic model_clear();
    for (int n = 0; n < N1; n++) begin m1[n] = 0; r1[n] = 0; end
    for (int n = 0; n < N2; n++) begin m2[n] = 0; r2[n] = 0; cnt[n] = 0; end
    l1 = '0; l2 = '0; s = 0;
  endtask

  task automatic push_zero();
    exp_t e;
    e = '0;
    sb_q.push_back(e);
  endtask

  // One clock edge of the network computed from the behavioural rules
  task automatic model_step();
    exp_t e;
    bit [N1-1:0] nl1;
    bit [N2-1:0] nl2;
    int sum, acc, d, idx, sel;
    e = '0; nl1 = '0; nl2 = '0;
    if (reset) begin
      model_clear();
      sb_q.push_back(e);
      return;
    end
    sel = int'(dbg_sel);
    e.dbg = (sel < N1) ? MB'(m1[sel]) : ((sel < N1 + N2) ? MB'(m2[sel-N1]) : '0);
    if (enable) begin
      in_hist[s] = input_spikes;
      for (int n = 0; n < N1; n++) begin
        sum = 0;
        for (int i = 0; i < M1; i++) begin
          d = delays1[n*M1+i] ? int'(delay_values1[(n*M1+i)*DW +: DW]) : 0;
          idx = s - d;
          if (idx >= 0 && in_hist[idx][i]) sum += wval(weights1[(n*M1+i)*WB +: WB]);
        end
        if (r1[n] > 0) begin r1[n]--; m1[n] = 0; end
        else begin
          acc = clampv(m1[n] + sum - int'(decay1));
          if (acc >= int'(threshold1)) begin nl1[n] = 1'b1; m1[n] = 0; r1[n] = int'(refractory1); end
          else m1[n] = acc;
        end
      end
      for (int n = 0; n < N2; n++) begin
        sum = 0;
        for (int i = 0; i < N1; i++) begin
          d = delays2[n*N1+i] ? int'(delay_values2[(n*N1+i)*DW +: DW]) : 0;
          idx = s - 1 - d;
          if (idx >= 0 && l1_hist[idx][i]) sum += wval(weights2[(n*N1+i)*WB +: WB]);
        end
        if (r2[n] > 0) begin r2[n]--; m2[n] = 0; end
        else begin
          acc = clampv(m2[n] + sum - int'(decay2));
          if (acc >= int'(threshold2)) begin nl2[n] = 1'b1; m2[n] = 0; r2[n] = int'(refractory2); end
          else m2[n] = acc;
        end
      end
      l1 = nl1; l2 = nl2; l1_hist[s] = nl1; s++;
    end
    for (int n = 0; n < N2; n++) begin
      if (count_clear) cnt[n] = 0;
      else if (enable && nl2[n] && cnt[n] < CMAX) cnt[n]++;
      e.cnt[n*CW +: CW] = CW'(cnt[n]);
    end
    e.l1 = l1; e.l2 = l2;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every pending expectation against the live outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("l1_spikes", 32'(output_spikes_l1), 32'(e.l1));
        chk("l2_spikes", 32'(output_spikes), 32'(e.l2));
        chk("spike_count", 32'(spike_count), 32'(e.cnt));
        chk("dbg_membrane", 32'(dbg_membrane), 32'(e.dbg));
      end
    end
  end

  task automatic clear_cfg();
    weights1 = '0; weights2 = '0; delays1 = '0; delays2 = '0;
    delay_values1 = '0; delay_values2 = '0;
    threshold1 = '0; threshold2 = '1; decay1 = '0; decay2 = '0;
    refractory1 = '0; refractory2 = '0; input_spikes = '0; count_clear = 1'b0;
  endtask

  function automatic logic [WB-1:0] rand_w();
    int r;
    r = $urandom % 8;
    return (r < 4) ? 2'b01 : ((r < 5) ? 2'b00 : ((r < 7) ? 2'b11 : 2'b10));
  endfunction

  task automatic rand_cfg();
    for (int k = 0; k < N1*M1; k++) begin
      weights1[k*WB +: WB] = rand_w();
      delays1[k] = 1'($urandom % 2);
      delay_values1[k*DW +: DW] = DW'($urandom);
    end
    for (int k = 0; k < N2*N1; k++) begin
      weights2[k*WB +: WB] = rand_w();
      delays2[k] = 1'($urandom % 2);
      delay_values2[k*DW +: DW] = DW'($urandom);
    end
    threshold1 = MB'($urandom_range(0, 20)); threshold2 = MB'($urandom_range(0, 4));
    decay1 = MB'($urandom_range(0, 3)); decay2 = MB'($urandom_range(0, 2));
    refractory1 = RB'($urandom); refractory2 = RB'($urandom);
  endtask

  // Asynchronous reset between edges, checked before the next clock edge
  task automatic mid_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    model_clear();
    push_zero();
    -> mon_ev;
    enable = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    clear_cfg();
    reset = 1'b1; enable = 1'b0; dbg_sel = '0;
    model_clear();
    repeat (2) step();
    reset = 1'b0;
    step();

    // Integrate and fire on a single +1 synapse, threshold 3
    weights1[0 +: WB] = 2'b01; threshold1 = 6'd3; input_spikes = 24'h1; enable = 1'b1;
    repeat (5) step();

    // Delayed synapse: one pulse, membrane rises five steps later
    clear_cfg(); threshold1 = 6'd63;
    weights1[0 +: WB] = 2'b01; delays1[0] = 1'b1; delay_values1[0 +: DW] = 3'd5;
    input_spikes = 24'h1; step(); input_spikes = '0;
    repeat (8) step();

    // Saturation with all inputs at +1, then leak of 2 per step
    clear_cfg(); threshold1 = 6'd63;
    for (int i = 0; i < M1; i++) weights1[i*WB +: WB] = 2'b01;
    input_spikes = '1; repeat (4) step();
    threshold1 = 6'd63; weights1[0 +: WB] = 2'b01;
    input_spikes = 24'h1; step();
    input_spikes = '0; decay1 = 6'd2; threshold1 = 6'd63; dbg_sel = 4'd0;
    for (int i = 0; i < M1; i++) weights1[i*WB +: WB] = 2'b00;
    input_spikes = '1; for (int i = 0; i < M1; i++) weights1[i*WB +: WB] = 2'b01;
    repeat (2) step();
    input_spikes = '0; repeat (35) step();

    // Refractory period with layer 2 following one step later
    clear_cfg(); refractory1 = 2'd2; threshold1 = 6'd1; weights1[0 +: WB] = 2'b01;
    weights2[0 +: WB] = 2'b01; threshold2 = 6'd1; input_spikes = 24'h1;
    dbg_sel = 4'd8;
    repeat (12) step();

    // Counter saturation at 255, clear has priority, clear while idle
    threshold2 = 6'd0; refractory2 = 2'd0;
    repeat (270) step();
    count_clear = 1'b1; step(); count_clear = 1'b0;
    repeat (3) step();
    enable = 1'b0; count_clear = 1'b1; step(); count_clear = 1'b0;
    repeat (2) step();
    enable = 1'b1;

    // Debug selection of the last layer-2 neuron and out-of-range indices
    threshold2 = 6'd40; weights2[(N1+0)*WB +: WB] = 2'b01;
    dbg_sel = 4'd9; repeat (4) step();
    dbg_sel = 4'd10; repeat (2) step();
    dbg_sel = 4'd15; repeat (2) step();

    // Reset while membranes are active
    mid_reset();

    // Randomized operation with live config changes and occasional resets
    for (int c = 0; c < 700; c++) begin
      if (c % 100 == 0) rand_cfg();
      if (c == 350) mid_reset();
      enable = ($urandom % 8) != 0;
      input_spikes = M1'($urandom & $urandom);
      count_clear = ($urandom % 60) == 0;
      dbg_sel = SW'($urandom);
      step();
    end

    repeat (2) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
